sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Parametrised N-channel arbiter in front of the SDRAM controller's Avalon-MM slave in mysystem.
//  Engine-side clients (move generators, transposition table, search cores) each get a simple
//  req/grant port; one Avalon-MM master is driven with round-robin fairness.
//  Supports pipelined reads with up to MAX_OUTSTANDING reads in flight; read data is routed back
//  to the issuing channel in order.
//  Adds channel count, width and pipelining that the single-master system wiring does not have.
// PARAMETERS
//  N_CH            4   number of client channels (2..8)
//  ADDR_W          25  word address width (13 row + 2 bank + 10 col)
//  DATA_W          16  data width; must be a multiple of 8
//  MAX_OUTSTANDING 4   read-ID FIFO depth (power of 2, >=2)
// PORTS
//  clk               in   1               system clock (50 MHz domain)
//  reset             in   1               synchronous, active-high
//  ch_req            in   N_CH            per-channel request; hold req/we/addr/wdata/be until grant
//  ch_we             in   N_CH            1 = write, 0 = read
//  ch_addr           in   N_CH*ADDR_W     channel i at [i*ADDR_W +: ADDR_W]
//  ch_wdata          in   N_CH*DATA_W     write data, packed as ch_addr
//  ch_be             in   N_CH*DATA_W/8   byte enables, packed as ch_addr
//  ch_grant          out  N_CH            one-hot pulse: command accepted by slave this cycle
//  ch_rvalid         out  N_CH            one-hot pulse: ch_rdata valid for that channel
//  ch_rdata          out  DATA_W          shared read data bus
//  avm_address       out  ADDR_W          Avalon-MM master command signals
//  avm_read          out  1
//  avm_write         out  1
//  avm_writedata     out  DATA_W
//  avm_byteenable    out  DATA_W/8
//  avm_waitrequest   in   1
//  avm_readdata      in   DATA_W
//  avm_readdatavalid in   1
//  protocol_err      out  1               sticky: readdatavalid with no read outstanding
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; ID FIFO empty, count=0; RR search starts at channel 0.
//  FSM IDLE: a channel is eligible if ch_req=1 and (ch_we=1 or count<MAX_OUTSTANDING).
//  - Pick the first eligible channel searching from ptr upward mod N_CH, and register its
//    command onto avm_*. Assert avm_read or avm_write. Go to ISSUE. No eligible channel: stay IDLE.
//  FSM ISSUE: hold avm_* stable while avm_waitrequest=1.
//  - When avm_waitrequest=0: ch_grant[sel]=1 combinationally in that cycle, ptr=sel+1 mod N_CH.
//  - In the same cycle, if the command is a read, push sel into the ID FIFO.
//  - Next cycle avm_read/avm_write=0 and FSM=IDLE.
//  - Minimum 2 cycles per command. Requester may change fields the cycle after grant.
//  Read return: on avm_readdatavalid=1 pop the FIFO head h. Next cycle ch_rvalid[h]=1 and
//  ch_rdata=avm_readdata (1-cycle latency). Otherwise ch_rvalid=0 and ch_rdata holds.
//  Simultaneous push and pop: both occur; count unchanged; pop returns the older entry.
//  Full (count=MAX): reads are ineligible, but writes from any channel are still granted.
//  A full FIFO with a pop in the same cycle still counts as full for that cycle's arbitration.
//  Empty + readdatavalid: data dropped, no ch_rvalid, protocol_err=1 until reset.
//  Reset mid-operation: command abandoned, FIFO flushed. Post-reset stray returns set protocol_err.
//  count width = clog2(MAX_OUTSTANDING)+1; FIFO pointers wrap mod MAX_OUTSTANDING.
// TESTING
//  1 ch2 write addr 0x100 data 0xBEEF be 2'b11, waitrequest=0
//    -> avm_write=1 for 1 cycle with those values; ch_grant=4'b0100 that same cycle.
//  2 All 4 channels hold read req, readdatavalid returns each read 2 cycles later
//    -> grant order 0,1,2,3,0,1,...; no channel is granted twice before the others.
//  3 waitrequest=1 for 3 cycles on a ch1 read
//    -> avm_* stable for 4 cycles; ch_grant[1] only in the 4th; FIFO count 0->1.
//  4 Five back-to-back reads (ch0) with no return, plus a ch3 write
//    -> 4 reads accepted, then ch3 write granted, then stall;
//    -> one readdatavalid -> 5th read issued.
//  5 Reads ch1,ch3,ch1 return 0xAAAA,0xBBBB,0xCCCC; return 2 coincides with a new push
//    -> ch_rvalid[1]/AAAA, [3]/BBBB, [1]/CCCC, each 1 cycle after readdatavalid.
//  6 readdatavalid while FIFO empty -> protocol_err=1, stays 1; reset pulse -> protocol_err=0,
//    outputs 0, next arbitration starts at ch0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of client req/grant channels and the Avalon-MM master command/return signals.
// The arbiter takes the master view; clients and the SDRAM slave sit on the slave view.
interface sdram_port_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [N_CH-1:0]        ch_req;
  logic [N_CH-1:0]        ch_we;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*DATA_W-1:0] ch_wdata;
  logic [N_CH*BE_W-1:0]   ch_be;
  logic [N_CH-1:0]        ch_grant;
  logic [N_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]      ch_rdata;

  logic [ADDR_W-1:0]      avm_address;
  logic                   avm_read;
  logic                   avm_write;
  logic [DATA_W-1:0]      avm_writedata;
  logic [BE_W-1:0]        avm_byteenable;
  logic                   avm_waitrequest;
  logic [DATA_W-1:0]      avm_readdata;
  logic                   avm_readdatavalid;
  logic                   protocol_err;

  modport master (
    input  ch_req, ch_we, ch_addr, ch_wdata, ch_be,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output ch_grant, ch_rvalid, ch_rdata,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output protocol_err
  );

  modport slave (
    output ch_req, ch_we, ch_addr, ch_wdata, ch_be,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  ch_grant, ch_rvalid, ch_rdata,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  protocol_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin N-channel arbiter onto one Avalon-MM master, with an in-order read-ID FIFO
// that steers pipelined read returns back to the channel that issued them.
module sdram_port_arbiter #(
  parameter int N_CH            = 4,
  parameter int ADDR_W          = 25,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 clk,
  input logic                 reset,
  sdram_port_arbiter_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [N_CH-1:0]   grant;
  logic              push, pop;

  logic [CH_W-1:0]   id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [N_CH-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              perr_q, perr_d;

  logic [N_CH-1:0]   eligible;
  logic              found;
  logic [CH_W-1:0]   pick;
  logic [CH_W:0]     sum;

  // Round-robin search from ptr_q upward; a full ID FIFO blocks reads only.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < N_CH; i++) begin
      eligible[i] = bus.ch_req[i] & (bus.ch_we[i] | (count_q < CNT_MAX));
    end
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
      if (!found && eligible[sum[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    grant   = '0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        sel_d   = pick;
        addr_d  = bus.ch_addr[pick*ADDR_W +: ADDR_W];
        wdata_d = bus.ch_wdata[pick*DATA_W +: DATA_W];
        be_d    = bus.ch_be[pick*BE_W +: BE_W];
        rd_d    = ~bus.ch_we[pick];
        wr_d    = bus.ch_we[pick];
        state_d = ISSUE;
      end
      ISSUE: if (!bus.avm_waitrequest) begin
        grant[sel_q] = 1'b1;
        ptr_d        = (sel_q == CH_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
        push         = rd_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A return with nothing outstanding is dropped and flagged; a same-cycle push does not help it.
  always_comb begin
    pop      = bus.avm_readdatavalid && (count_q != '0);
    rvalid_d = '0;
    rdata_d  = rdata_q;
    perr_d   = perr_q;
    if (pop) begin
      rvalid_d[id_mem[rd_ptr_q]] = 1'b1;
      rdata_d                    = bus.avm_readdata;
    end
    if (bus.avm_readdatavalid && (count_q == '0)) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      perr_q   <= perr_d;
    end
  end

  // NOTE: the ID storage is not reset; count_q and the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= sel_q;
  end

  assign bus.ch_grant       = grant;
  assign bus.ch_rvalid      = rvalid_q;
  assign bus.ch_rdata       = rdata_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = be_q;
  assign bus.protocol_err   = perr_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: scoreboards of expected grants and read returns,
// with an Avalon slave model that can auto-return reads or accept injected returns.
module tb_sdram_port_arbiter;
  localparam int N_CH   = 4;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int MAXO   = 4;
  localparam logic [15:0] XOR_KEY = 16'h5A5A;

  typedef struct {
    int               ch;
    logic             we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } cmd_t;
  typedef struct {
    int               ch;
    logic [DATA_W-1:0] data;
  } ret_t;
  typedef struct {
    int               due;
    logic [DATA_W-1:0] data;
  } sched_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic auto_ret = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;

  cmd_t   exp_grant_q[$];
  ret_t   exp_id_q[$];
  sched_t ret_q[$];
  cmd_t   mon_e;
  ret_t   due;
  logic   due_v = 1'b0;

  sdram_port_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  sdram_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int ch, logic we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wd, logic [1:0] be);
    bus.ch_req[ch]                     = 1'b1;
    bus.ch_we[ch]                      = we;
    bus.ch_addr[ch*ADDR_W +: ADDR_W]   = addr;
    bus.ch_wdata[ch*DATA_W +: DATA_W]  = wd;
    bus.ch_be[ch*2 +: 2]               = be;
  endtask

  task automatic clr_ch(int ch);
    bus.ch_req[ch] = 1'b0;
  endtask

  task automatic expect_grant(int ch, logic we, logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] wd, logic [1:0] be);
    exp_grant_q.push_back('{ch, we, addr, wd, be});
  endtask

  // Wait (bounded) until the expected-grant queue has drained to 'target' entries.
  task automatic wait_grants(int target, int max_cyc);
    int n = 0;
    while (exp_grant_q.size() > target && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_grants", exp_grant_q.size(), target);
  endtask

  // Schedule one readdatavalid beat for the next cycle.
  task automatic inject(logic [DATA_W-1:0] data);
    @(negedge clk);
    ret_q.push_back('{cyc + 1, data});
  endtask

  // Avalon slave: drives readdatavalid from the schedule; in auto mode a read accepted
  // in cycle c returns in cycle c+2 with data = address ^ XOR_KEY.
  initial begin
    cyc = 0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = 16'hDEAD;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = ret_q[0].data;
        void'(ret_q.pop_front());
      end
      @(negedge clk);
      if (auto_ret && bus.avm_read && !bus.avm_waitrequest)
        ret_q.push_back('{cyc + 2, bus.avm_address[15:0] ^ XOR_KEY});
    end
  end

  // Scoreboard: grants against expected commands, read returns against the expected ID order.
  always @(negedge clk) begin
    if (reset) begin
      exp_id_q.delete();
      due_v = 1'b0;
    end else begin
      if (due_v) begin
        check("rvalid_ch", bus.ch_rvalid, 32'(1) << due.ch);
        check("rdata", bus.ch_rdata, due.data);
      end else if (bus.ch_rvalid != '0) begin
        check("rvalid_spurious", bus.ch_rvalid, 0);
      end
      due_v = 1'b0;
      if (bus.avm_readdatavalid && exp_id_q.size() > 0) begin
        due   = exp_id_q.pop_front();
        due_v = 1'b1;
      end
      if (bus.ch_grant != '0) begin
        if (exp_grant_q.size() == 0) begin
          check("grant_unexpected", bus.ch_grant, 0);
        end else begin
          mon_e = exp_grant_q.pop_front();
          check("grant", bus.ch_grant, 32'(1) << mon_e.ch);
          check("avm_write", bus.avm_write, mon_e.we);
          check("avm_read", bus.avm_read, !mon_e.we);
          check("avm_address", bus.avm_address, mon_e.addr);
          if (mon_e.we) begin
            check("avm_writedata", bus.avm_writedata, mon_e.wdata);
            check("avm_byteenable", bus.avm_byteenable, mon_e.be);
          end else begin
            exp_id_q.push_back('{mon_e.ch, mon_e.addr[15:0] ^ XOR_KEY});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(string tag);
    check({tag, "_read"}, bus.avm_read, 0);
    check({tag, "_write"}, bus.avm_write, 0);
    check({tag, "_addr"}, bus.avm_address, 0);
    check({tag, "_grant"}, bus.ch_grant, 0);
    check({tag, "_rvalid"}, bus.ch_rvalid, 0);
    check({tag, "_rdata"}, bus.ch_rdata, 0);
    check({tag, "_perr"}, bus.protocol_err, 0);
    check({tag, "_count"}, 32'(dut.count_q), 0);
  endtask

  initial begin
    bus.ch_req = '0;
    bus.ch_we = '0;
    bus.ch_addr = '0;
    bus.ch_wdata = '0;
    bus.ch_be = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    reset = 1'b0;

    // All four channels reading: strict rotation 0,1,2,3,0,1,2,3; each read returns 2 cycles later.
    auto_ret = 1'b1;
    for (int i = 0; i < N_CH; i++) set_ch(i, 1'b0, ADDR_W'(16'h0010 + i), '0, 2'b00);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N_CH; i++) expect_grant(i, 1'b0, ADDR_W'(16'h0010 + i), '0, 2'b00);
    wait_grants(0, 40);
    tick();
    bus.ch_req = '0;
    repeat (4) tick();
    check("t2_drain", exp_id_q.size(), 0);

    // Single ch2 write with no wait states: one command cycle, grant in the same cycle.
    set_ch(2, 1'b1, 25'h100, 16'hBEEF, 2'b11);
    expect_grant(2, 1'b1, 25'h100, 16'hBEEF, 2'b11);
    @(negedge clk);
    check("t1_pre_write", bus.avm_write, 0);
    @(negedge clk);
    check("t1_write", bus.avm_write, 1);
    check("t1_addr", bus.avm_address, 25'h100);
    check("t1_wdata", bus.avm_writedata, 16'hBEEF);
    check("t1_be", bus.avm_byteenable, 2'b11);
    check("t1_grant", bus.ch_grant, 4'b0100);
    tick();
    clr_ch(2);
    @(negedge clk);
    check("t1_write_drop", bus.avm_write, 0);
    check("t1_grant_drop", bus.ch_grant, 0);
    tick();

    // ch1 read held off by three waitrequest cycles.
    bus.avm_waitrequest = 1'b1;
    set_ch(1, 1'b0, 25'h40, '0, 2'b00);
    expect_grant(1, 1'b0, 25'h40, '0, 2'b00);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_read_held", bus.avm_read, 1);
      check("t3_addr_held", bus.avm_address, 25'h40);
      check("t3_no_grant", bus.ch_grant, 0);
      check("t3_count0", 32'(dut.count_q), 0);
    end
    tick();
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_grant1", bus.ch_grant[1], 1);
    check("t3_read_4th", bus.avm_read, 1);
    check("t3_count_at_grant", 32'(dut.count_q), 0);
    tick();
    clr_ch(1);
    @(negedge clk);
    check("t3_read_drop", bus.avm_read, 0);
    check("t3_count1", 32'(dut.count_q), 1);
    repeat (6) tick();
    check("t3_drain", exp_id_q.size(), 0);

    // Fill the ID FIFO from ch0, then a ch3 write still gets through, then reads stall.
    auto_ret = 1'b0;
    set_ch(0, 1'b0, 25'h200, '0, 2'b00);
    repeat (MAXO) expect_grant(0, 1'b0, 25'h200, '0, 2'b00);
    wait_grants(0, 40);
    tick();
    set_ch(3, 1'b1, 25'h300, 16'h1234, 2'b01);
    expect_grant(3, 1'b1, 25'h300, 16'h1234, 2'b01);
    wait_grants(0, 20);
    tick();
    clr_ch(3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_stall_read", bus.avm_read, 0);
      check("t4_stall_grant", bus.ch_grant, 0);
    end
    check("t4_count_full", 32'(dut.count_q), MAXO);
    expect_grant(0, 1'b0, 25'h200, '0, 2'b00);
    inject(16'h0200 ^ XOR_KEY);
    @(negedge clk);
    check("t4_pop_cycle_no_read", bus.avm_read, 0);
    @(negedge clk);
    check("t4_full_same_cycle", bus.avm_read, 0);
    @(negedge clk);
    check("t4_fifth_read", bus.avm_read, 1);
    tick();
    clr_ch(0);
    repeat (MAXO) inject(16'h0200 ^ XOR_KEY);
    repeat (3) tick();
    check("t4_drain", exp_id_q.size(), 0);
    check("t4_count_empty", 32'(dut.count_q), 0);

    // Reads ch1, ch3, ch1 returning AAAA, BBBB, CCCC; each return lands on the next grant's push.
    auto_ret = 1'b1;
    set_ch(1, 1'b0, 25'(16'hAAAA ^ XOR_KEY), '0, 2'b00);
    set_ch(3, 1'b0, 25'(16'hBBBB ^ XOR_KEY), '0, 2'b00);
    expect_grant(1, 1'b0, 25'(16'hAAAA ^ XOR_KEY), '0, 2'b00);
    expect_grant(3, 1'b0, 25'(16'hBBBB ^ XOR_KEY), '0, 2'b00);
    expect_grant(1, 1'b0, 25'(16'hCCCC ^ XOR_KEY), '0, 2'b00);
    wait_grants(2, 20);
    tick();
    bus.ch_addr[1*ADDR_W +: ADDR_W] = 25'(16'hCCCC ^ XOR_KEY);
    wait_grants(1, 20);
    tick();
    clr_ch(3);
    wait_grants(0, 20);
    tick();
    clr_ch(1);
    repeat (5) tick();
    check("t5_drain", exp_id_q.size(), 0);

    // Stray return sets sticky protocol_err; reset mid-command clears everything.
    inject(16'h7777);
    @(negedge clk);
    check("t6_perr_before", bus.protocol_err, 0);
    @(negedge clk);
    check("t6_perr_set", bus.protocol_err, 1);
    check("t6_no_rvalid", bus.ch_rvalid, 0);
    repeat (3) tick();
    check("t6_perr_sticky", bus.protocol_err, 1);
    bus.avm_waitrequest = 1'b1;
    set_ch(2, 1'b1, 25'h55, 16'h0001, 2'b11);
    repeat (2) tick();
    check("t6_stuck_write", bus.avm_write, 1);
    reset = 1'b1;
    clr_ch(2);
    tick();
    @(negedge clk);
    check_idle_outputs("t6_reset");
    tick();
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    set_ch(0, 1'b0, 25'h10, '0, 2'b00);
    set_ch(3, 1'b0, 25'h13, '0, 2'b00);
    expect_grant(0, 1'b0, 25'h10, '0, 2'b00);
    expect_grant(3, 1'b0, 25'h13, '0, 2'b00);
    wait_grants(1, 20);
    tick();
    clr_ch(0);
    wait_grants(0, 20);
    tick();
    clr_ch(3);
    repeat (6) tick();
    check("final_id_drain", exp_id_q.size(), 0);
    check("final_perr_clear", bus.protocol_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
